multicycle_control: RTL and testbench



---
 rtl/mips_pkg.sv | 38 +++
 rtl/alu_decoder.sv | 23 ++
 rtl/multicycle_control.sv | 159 +++++++++++++++
 tb/tb_multicycle_control.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
package mips_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation, with a legality flag for unsupported functs.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       legal
);

   always_comb begin
      alu_control = ALU_ADD;
      legal       = 1'b1;
      case (funct)
         FN_ADD:  alu_control = ALU_ADD;
         FN_SUB:  alu_control = ALU_SUB;
         FN_AND:  alu_control = ALU_AND;
         FN_OR:   alu_control = ALU_OR;
         FN_SLT:  alu_control = ALU_SLT;
         default: legal       = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS datapath: one state per cycle, outputs
// decoded from the state register, memory accesses stretched by mem_ready.
module multicycle_control
   import mips_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               iord,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_srca,
   output logic [1:0]         alu_srcb,
   output logic [2:0]         alu_control,
   output logic [1:0]         pc_src,
   output logic               pc_en,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   state_t     state_q;
   logic       is_sw_q;
   logic [2:0] fn_alu;
   logic       fn_legal;
   logic       op_known;

   alu_decoder u_alu_decoder (
      .funct       (funct),
      .alu_control (fn_alu),
      .legal       (fn_legal)
   );

   always_comb begin
      op_known = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
         default:                                       op_known = 1'b0;
      endcase
   end

   // MEMADR cannot look at op, so the lw/sw choice is captured in DECODE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         is_sw_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH:    if (mem_ready) state_q <= DECODE;
            DECODE: begin
               is_sw_q <= (op == OP_SW);
               case (op)
                  OP_LW, OP_SW: state_q <= MEMADR;
                  OP_RTYPE:     state_q <= fn_legal ? EXECUTE : FETCH;
                  OP_BEQ:       state_q <= BRANCH;
                  OP_ADDI:      state_q <= ADDIEXEC;
                  OP_J:         state_q <= JUMP;
                  default:      state_q <= FETCH;
               endcase
            end
            MEMADR:   state_q <= is_sw_q ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_q <= MEMWB;
            MEMWRITE: if (mem_ready) state_q <= FETCH;
            EXECUTE:  state_q <= ALUWB;
            ADDIEXEC: state_q <= ADDIWB;
            default:  state_q <= FETCH;
         endcase
      end
   end

   always_comb begin
      mem_req     = 1'b0;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_srca    = 1'b0;
      alu_srcb    = 2'b00;
      alu_control = ALU_ADD;
      pc_src      = 2'b00;
      pc_en       = 1'b0;
      illegal_op  = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req  = 1'b1;
            alu_srcb = 2'b01;
            ir_write = mem_ready;
            pc_en    = mem_ready;
         end
         DECODE: begin
            alu_srcb   = 2'b11;
            illegal_op = !op_known || (op == OP_RTYPE && !fn_legal);
         end
         MEMADR: begin
            alu_srca = 1'b1;
            alu_srcb = 2'b10;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEMWRITE: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         EXECUTE: begin
            alu_srca    = 1'b1;
            alu_control = fn_alu;
         end
         ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_srca    = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            pc_en       = zero;
         end
         ADDIEXEC: begin
            alu_srca = 1'b1;
            alu_srcb = 2'b10;
         end
         ADDIWB:   reg_write = 1'b1;
         JUMP: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
         end
         default: ;
      endcase
      // Strobes are suppressed while reset is held so an aborted access never writes.
      if (reset) begin
         mem_req    = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         pc_en      = 1'b0;
         illegal_op = 1'b0;
      end
   end

   assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction table plus stall and reset sequences.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready;
   logic [5:0] op, funct;
   logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_srca, pc_en, illegal_op;
   logic [1:0] alu_srcb, pc_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multicycle_control #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
      .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
      .illegal_op(illegal_op), .state(state)
   );

   // {state, mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
   //  alu_srca, alu_srcb, alu_control, pc_src, pc_en, illegal_op}
   wire [20:0] act = {state, mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                      reg_write, alu_srca, alu_srcb, alu_control, pc_src, pc_en, illegal_op};

   typedef struct {
      string      name;
      logic [20:0] v;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      int          n;
      logic [23:0] sts;
   } vec_t;

   function automatic logic [3:0] fmap(input logic [5:0] f);
      case (f)
         6'b100000: return 4'b1_010;
         6'b100010: return 4'b1_110;
         6'b100100: return 4'b1_000;
         6'b100101: return 4'b1_001;
         6'b101010: return 4'b1_111;
         default:   return 4'b0_010;
      endcase
   endfunction

   function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic [5:0] o,
                                           input logic [5:0] f, input logic z,
                                           input logic mr, input logic rst);
      logic mreq, io, mw, irw, rd, m2r, rw, sa, pe, ill;
      logic [1:0] sb2, ps;
      logic [2:0] ac;
      logic [3:0] fm;
      logic       op_ok;
      {mreq, io, mw, irw, rd, m2r, rw, sa, pe, ill} = '0;
      sb2 = 2'b00; ps = 2'b00; ac = 3'b010;
      fm  = fmap(f);
      op_ok = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
              (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
      case (st)
         4'd0:  begin mreq = 1; sb2 = 2'b01; irw = mr; pe = mr; end
         4'd1:  begin sb2 = 2'b11; ill = !op_ok || (o == 6'b000000 && !fm[3]); end
         4'd2:  begin sa = 1; sb2 = 2'b10; end
         4'd3:  begin mreq = 1; io = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mreq = 1; io = 1; mw = 1; end
         4'd6:  begin sa = 1; ac = fm[2:0]; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
         4'd9:  begin sa = 1; sb2 = 2'b10; end
         4'd10: rw = 1;
         4'd11: begin ps = 2'b10; pe = 1; end
         default: ;
      endcase
      if (rst) {mreq, mw, irw, rw, pe, ill} = '0;
      return {st, mreq, io, mw, irw, rd, m2r, rw, sa, sb2, ac, ps, pe, ill};
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", e.name, act, e.v);
         end
      end
   end

   task automatic cyc(input string nm, input logic [3:0] st, input logic mr, input logic rst);
      exp_t e;
      mem_ready = mr;
      reset     = rst;
      e.name = nm;
      e.v    = exp_vec(st, op, funct, zero, mr, rst);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string nm, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input int n, input logic [23:0] s);
      vec_t v;
      v.name = nm; v.op = o; v.funct = f; v.zero = z; v.n = n; v.sts = s;
      return v;
   endfunction

   vec_t tbl[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk("lw",      6'b100011, 6'b000000, 1'b0, 5, 24'h012340);
      tbl[1]  = mk("sw",      6'b101011, 6'b000000, 1'b0, 4, 24'h012500);
      tbl[2]  = mk("add",     6'b000000, 6'b100000, 1'b0, 4, 24'h016700);
      tbl[3]  = mk("sub",     6'b000000, 6'b100010, 1'b0, 4, 24'h016700);
      tbl[4]  = mk("and",     6'b000000, 6'b100100, 1'b0, 4, 24'h016700);
      tbl[5]  = mk("or",      6'b000000, 6'b100101, 1'b0, 4, 24'h016700);
      tbl[6]  = mk("slt",     6'b000000, 6'b101010, 1'b0, 4, 24'h016700);
      tbl[7]  = mk("addi",    6'b001000, 6'b000000, 1'b0, 4, 24'h019A00);
      tbl[8]  = mk("beq_z1",  6'b000100, 6'b000000, 1'b1, 3, 24'h018000);
      tbl[9]  = mk("beq_z0",  6'b000100, 6'b000000, 1'b0, 3, 24'h018000);
      tbl[10] = mk("j",       6'b000010, 6'b000000, 1'b0, 3, 24'h01B000);
      tbl[11] = mk("ill_op",  6'b111111, 6'b000000, 1'b0, 2, 24'h010000);
      tbl[12] = mk("ill_fn",  6'b000000, 6'b000111, 1'b0, 2, 24'h010000);

      reset = 1'b1; mem_ready = 1'b0; op = '0; funct = '0; zero = 1'b0;
      @(posedge clk);
      #1;
      cyc("reset_hold_rdy", 4'd0, 1'b1, 1'b1);
      cyc("reset_hold",     4'd0, 1'b0, 1'b1);

      // Table: mem_ready tied high, each instruction must return to FETCH after n cycles.
      foreach (tbl[k]) begin
         op = tbl[k].op; funct = tbl[k].funct; zero = tbl[k].zero;
         for (int i = 0; i < tbl[k].n; i++)
            cyc($sformatf("%s_c%0d", tbl[k].name, i), tbl[k].sts[23-4*i -: 4], 1'b1, 1'b0);
      end

      // sw with FETCH stalled 2 cycles and MEMWRITE stalled 2 cycles.
      op = 6'b101011; funct = 6'b000000; zero = 1'b0;
      cyc("swst_fetch0", 4'd0, 1'b0, 1'b0);
      cyc("swst_fetch1", 4'd0, 1'b0, 1'b0);
      cyc("swst_fetch2", 4'd0, 1'b1, 1'b0);
      cyc("swst_decode", 4'd1, 1'b0, 1'b0);
      cyc("swst_memadr", 4'd2, 1'b1, 1'b0);
      cyc("swst_mw0",    4'd5, 1'b0, 1'b0);
      cyc("swst_mw1",    4'd5, 1'b0, 1'b0);
      cyc("swst_mw2",    4'd5, 1'b1, 1'b0);

      // lw with MEMREAD stalled once.
      op = 6'b100011;
      cyc("lwst_fetch",  4'd0, 1'b1, 1'b0);
      cyc("lwst_decode", 4'd1, 1'b0, 1'b0);
      cyc("lwst_memadr", 4'd2, 1'b0, 1'b0);
      cyc("lwst_mr0",    4'd3, 1'b0, 1'b0);
      cyc("lwst_mr1",    4'd3, 1'b1, 1'b0);
      cyc("lwst_wb",     4'd4, 1'b0, 1'b0);

      // Reset held 3 cycles in the middle of a stalled MEMWRITE.
      op = 6'b101011;
      cyc("rst_fetch",  4'd0, 1'b1, 1'b0);
      cyc("rst_decode", 4'd1, 1'b1, 1'b0);
      cyc("rst_memadr", 4'd2, 1'b1, 1'b0);
      cyc("rst_mw",     4'd5, 1'b0, 1'b0);
      cyc("rst_r0",     4'd5, 1'b0, 1'b1);
      cyc("rst_r1",     4'd0, 1'b0, 1'b1);
      cyc("rst_r2",     4'd0, 1'b1, 1'b1);
      cyc("rst_after",  4'd0, 1'b0, 1'b0);
      cyc("rst_after2", 4'd0, 1'b1, 1'b0);
      cyc("rst_decode2",4'd1, 1'b1, 1'b0);

      @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
